// File: rtl/board_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// board_ctrl : memory-game board controller (cursor, card status, turn hold)
// Revision   : 1.0
// ---------------------------------------------------------------------------
module board_ctrl #(
  parameter logic [63:0] LAYOUT      = 64'h7654_3210_7654_3210,
  parameter int unsigned HOLD_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next,
  input  logic        select,
  input  logic [1:0]  x,
  input  logic        par,
  input  logic [7:0]  selected1,
  input  logic [7:0]  selected2,
  output logic [7:0]  counter,
  output logic [3:0]  state,
  output logic        empty,
  output logic        player,
  output logic [15:0] revealed,
  output logic [15:0] matched,
  output logic        game_over
);

  localparam int unsigned   TW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_PLAY = 2'd0, S_HOLD = 2'd1, S_OVER = 2'd2} fsm_t;
  typedef enum logic [1:0] {C_HIDDEN = 2'd0, C_REVEALED = 2'd1, C_MATCHED = 2'd2} card_t;

  fsm_t          fsm_q;
  card_t         card_q [16];
  logic [3:0]    cnt_q;
  logic          player_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    sel1_q;
  logic [3:0]    sel2_q;

  logic unused_sel_hi;
  assign unused_sel_hi = ^{selected1[7:4], selected2[7:4]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q    <= S_PLAY;
      cnt_q    <= '0;
      player_q <= 1'b0;
      timer_q  <= '0;
      sel1_q   <= '0;
      sel2_q   <= '0;
      for (int i = 0; i < 16; i++) card_q[i] <= C_HIDDEN;
    end else begin
      unique case (fsm_q)
        S_PLAY: begin
          if (x[1]) begin
            fsm_q <= S_OVER;
          end else begin
            if (select && card_q[cnt_q] == C_HIDDEN) card_q[cnt_q] <= C_REVEALED;
            if (next) cnt_q <= cnt_q + 4'd1;
            // A match written after the reveal wins if both target one card.
            if (x == 2'b01) begin
              if (par) begin
                card_q[selected1[3:0]] <= C_MATCHED;
                card_q[selected2[3:0]] <= C_MATCHED;
              end else begin
                sel1_q  <= selected1[3:0];
                sel2_q  <= selected2[3:0];
                timer_q <= HOLD_LOAD;
                fsm_q   <= S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          if (x[1]) begin
            fsm_q <= S_OVER;
          end else begin
            if (next) cnt_q <= cnt_q + 4'd1;
            if (timer_q == '0) begin
              card_q[sel1_q] <= C_HIDDEN;
              card_q[sel2_q] <= C_HIDDEN;
              player_q       <= ~player_q;
              fsm_q          <= S_PLAY;
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
        end
        S_OVER: begin
        end
        default: fsm_q <= S_PLAY;
      endcase
    end
  end

  always_comb begin
    revealed = '0;
    matched  = '0;
    for (int i = 0; i < 16; i++) begin
      revealed[i] = (card_q[i] != C_HIDDEN);
      matched[i]  = (card_q[i] == C_MATCHED);
    end
  end

  assign counter   = {4'b0000, cnt_q};
  assign state     = LAYOUT[{cnt_q, 2'b00} +: 4];
  assign empty     = (fsm_q == S_PLAY) && (card_q[cnt_q] == C_HIDDEN);
  assign player    = player_q;
  assign game_over = (fsm_q == S_OVER);

endmodule
`default_nettype wire

// File: tb/tb_board_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_board_ctrl : scoreboard bench for board_ctrl with a behavioural game model
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_board_ctrl;

  localparam int          HOLD = 4;
  localparam logic [63:0] LAY  = 64'h7654_3210_7654_3210;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        next = 1'b0;
  logic        select = 1'b0;
  logic [1:0]  x = 2'b00;
  logic        par = 1'b0;
  logic [7:0]  s1 = 8'h00;
  logic [7:0]  s2 = 8'h00;
  logic [7:0]  counter;
  logic [3:0]  state;
  logic        empty;
  logic        player;
  logic [15:0] revealed;
  logic [15:0] matched;
  logic        game_over;

  board_ctrl #(.LAYOUT(LAY), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .next(next), .select(select), .x(x), .par(par),
    .selected1(s1), .selected2(s2), .counter(counter), .state(state),
    .empty(empty), .player(player), .revealed(revealed), .matched(matched),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  counter;
    logic [3:0]  state;
    logic        empty;
    logic        player;
    logic [15:0] rev;
    logic [15:0] mat;
    logic        go;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  event chk_ev;

  // Game model: card status 0 hidden, 1 face-up, 2 matched; m_hold = cycles of dwell left.
  int m_stat[16];
  int m_cur, m_hold, m_h1, m_h2;
  bit m_plr, m_over;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_stat[i] = 0;
    m_cur = 0; m_hold = 0; m_h1 = 0; m_h2 = 0; m_plr = 0; m_over = 0;
  endtask

  task automatic model_step(input bit n, input bit sl, input logic [1:0] xx,
                            input bit p, input int a, input int b);
    if (m_over) return;
    if (xx[1]) begin
      m_over = 1;
      return;
    end
    if (m_hold > 0) begin
      if (n) m_cur = (m_cur + 1) % 16;
      m_hold = m_hold - 1;
      if (m_hold == 0) begin
        m_stat[m_h1] = 0;
        m_stat[m_h2] = 0;
        m_plr = !m_plr;
      end
    end else begin
      if (sl && m_stat[m_cur] == 0) m_stat[m_cur] = 1;
      if (xx == 2'b01) begin
        if (p) begin
          m_stat[a] = 2;
          m_stat[b] = 2;
        end else begin
          m_hold = HOLD; m_h1 = a; m_h2 = b;
        end
      end
      if (n) m_cur = (m_cur + 1) % 16;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic [63:0] lay;
    lay = LAY;
    e.counter = 8'(m_cur);
    e.state   = lay[4*m_cur +: 4];
    e.empty   = !m_over && (m_hold == 0) && (m_stat[m_cur] == 0);
    e.player  = m_plr;
    for (int i = 0; i < 16; i++) begin
      e.rev[i] = (m_stat[i] != 0);
      e.mat[i] = (m_stat[i] == 2);
    end
    e.go = m_over;
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("counter",   16'(counter),   16'(e.counter));
        chk("state",     16'(state),     16'(e.state));
        chk("empty",     16'(empty),     16'(e.empty));
        chk("player",    16'(player),    16'(e.player));
        chk("revealed",  revealed,       e.rev);
        chk("matched",   matched,        e.mat);
        chk("game_over", 16'(game_over), 16'(e.go));
      end
    end
  end

  task automatic cyc(input bit n, input bit sl, input logic [1:0] xx, input bit p,
                     input logic [7:0] a, input logic [7:0] b);
    next = n; select = sl; x = xx; par = p; s1 = a; s2 = b;
    model_step(n, sl, xx, p, int'(a[3:0]), int'(b[3:0]));
    @(posedge clk);
    #1;
    sb.push_back(model_out());
  endtask

  // Reset asserted mid-cycle and checked before any clock edge arrives.
  task automatic do_reset();
    @(negedge clk);
    #2;
    next = 0; select = 0; x = 2'b00; par = 0; s1 = 8'h00; s2 = 8'h00;
    rst = 1'b0;
    model_reset();
    #1;
    sb.push_back(model_out());
    ->chk_ev;
    @(posedge clk);
    #1;
    sb.push_back(model_out());
    rst = 1'b1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 2'b00, 0, 8'h00, 8'h00);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int r;
    logic [1:0] xx;
    model_reset();
    do_reset();
    // Cursor walk and wrap
    for (int i = 0; i < 3; i++) cyc(1, 0, 2'b00, 0, 8'h00, 8'h00);
    for (int i = 0; i < 13; i++) cyc(1, 0, 2'b00, 0, 8'h00, 8'h00);
    // Held select on card 2, then a matching turn on 1 and 9
    cyc(1, 0, 2'b00, 0, 8'h00, 8'h00);
    cyc(1, 0, 2'b00, 0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 1, 2'b00, 0, 8'h00, 8'h00);
    cyc(0, 0, 2'b01, 1, 8'h01, 8'h09);
    idle(2);
    // Mismatch on 0 and 3 with select/next activity during the dwell
    do_reset();
    cyc(0, 1, 2'b00, 0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1, 0, 2'b00, 0, 8'h00, 8'h00);
    cyc(0, 1, 2'b00, 0, 8'h00, 8'h00);
    cyc(0, 0, 2'b01, 0, 8'hF0, 8'hA3);
    cyc(1, 1, 2'b00, 0, 8'h00, 8'h00);
    cyc(0, 1, 2'b01, 1, 8'h05, 8'h06);
    cyc(1, 1, 2'b00, 0, 8'h00, 8'h00);
    cyc(0, 1, 2'b00, 0, 8'h07, 8'h08);
    idle(3);
    // Same-index pair marked matched
    cyc(0, 0, 2'b01, 1, 8'h2C, 8'h0C);
    idle(1);
    // Reset mid-dwell
    cyc(0, 1, 2'b00, 0, 8'h00, 8'h00);
    cyc(0, 0, 2'b01, 0, 8'h04, 8'h05);
    idle(2);
    do_reset();
    idle(2);
    // Game over from PLAY; everything afterwards frozen
    cyc(0, 1, 2'b00, 0, 8'h00, 8'h00);
    cyc(0, 0, 2'b10, 0, 8'h00, 8'h00);
    cyc(1, 1, 2'b01, 1, 8'h03, 8'h04);
    cyc(0, 1, 2'b01, 0, 8'h00, 8'h01);
    idle(2);
    // Randomized games
    for (int g = 0; g < 4; g++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        r = $urandom_range(0, 99);
        if (r < 12) xx = 2'b01;
        else if (r == 99 && i > 250) xx = {1'b1, 1'($urandom_range(0, 1))};
        else xx = 2'b00;
        cyc(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), xx,
            1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      end
    end
    @(negedge clk);
    #1;
    chk("sb_drain", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_ctrl.md
BOARD_CTRL -- requirements
Module: board_ctrl

Interface
REQ-001 Parameter LAYOUT, 64'h7654_3210_7654_3210, card i value = LAYOUT[4i+3:4i], i = 0..15.
REQ-002 Parameter HOLD_CYCLES, 25_000_000, cycles a mismatched pair stays face-up before it is hidden again.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 next  in  1  cursor-advance pulse, one cycle wide.
REQ-006 select  in  1  flip request for the card under the cursor; level, may stay high for many cycles.
REQ-007 x  in  2  turn-stage result: 00 idle, 01 turn complete, 10 winner, 11 tie.
REQ-008 par  in  1  turn-stage pair flag; valid only in cycles where x==01.
REQ-009 selected1  in  8  first card index of the completed turn; valid when x==01.
REQ-010 selected2  in  8  second card index of the completed turn; valid when x==01.
REQ-011 counter  out  8  cursor index, 0..15, upper 4 bits always 0.
REQ-012 state  out  4  value of the card under the cursor, LAYOUT[4*counter+3:4*counter], combinational from counter.
REQ-013 empty  out  1  1 when the card under the cursor is HIDDEN and the FSM is in PLAY.
REQ-014 player  out  1  current player, 0 = J1, 1 = J2.
REQ-015 revealed  out  16  bit i = card i face-up (REVEALED or MATCHED).
REQ-016 matched  out  16  bit i = card i MATCHED.
REQ-017 game_over  out  1  1 in OVER.

Function
REQ-018 Each card has a 2-bit status: HIDDEN, REVEALED or MATCHED.
REQ-019 FSM states: PLAY, HOLD, OVER.
REQ-020 PLAY + next: counter <= (counter+1) mod 16. The cursor wraps from 15 to 0.
REQ-021 PLAY + select + card[counter]==HIDDEN: card becomes REVEALED on that edge, so empty falls the next cycle. A held select therefore flips only one card.
REQ-022 select on a REVEALED or MATCHED card, or outside PLAY: ignored.
REQ-023 next and select in the same cycle: the reveal applies to the old counter, then the cursor advances.
REQ-024 PLAY + x==01 + par==1: cards selected1[3:0] and selected2[3:0] become MATCHED; player is unchanged; stay in PLAY.
REQ-025 PLAY + x==01 + par==0: load the hold timer with HOLD_CYCLES-1 and go to HOLD.
REQ-026 HOLD: decrement the timer each cycle. At 0, both selected cards return to HIDDEN, player toggles, and the FSM returns to PLAY. Total dwell is exactly HOLD_CYCLES cycles.
REQ-027 selected1/selected2 are registered when x==01 and used for the HIDDEN update; later input changes do not affect the update.
REQ-028 next is honoured in HOLD (cursor moves); select is not.
REQ-029 x==10 or x==11 in any state: go to OVER next edge, card status frozen, game_over=1.
REQ-030 OVER is left only by reset.
REQ-031 x==01 with selected1==selected2 and par==1: that one card is marked MATCHED, no error raised.
REQ-032 x==01 arriving in HOLD: ignored.
REQ-033 Only the low 4 bits of selected1/selected2 are used.

Reset
REQ-034 rst low (asynchronous, any cycle, including mid-HOLD): FSM=PLAY, counter=0, player=0, all cards HIDDEN, timer=0, revealed=0, matched=0, game_over=0, empty=1.
REQ-035 Operation resumes on the first rising clk edge after rst deasserts.

Verification (bench HOLD_CYCLES=4, default LAYOUT)
REQ-036 Reset, 3 next pulses -> counter=3, state=3, empty=1; 13 more next pulses -> counter=0 (wrap).
REQ-037 At counter=2, select held 5 cycles -> revealed=16'h0004, empty=0 from the cycle after the first select.
REQ-038 x=01, par=1, selected1=1, selected2=9 -> matched=16'h0202, player=0, FSM stays in PLAY.
REQ-039 x=01, par=0, selected1=0, selected2=3, with both revealed -> revealed holds 16'h0009 for 4 cycles, then 0; player=1; select during HOLD ignored.
REQ-040 x=10 during PLAY -> game_over=1 next cycle; later select/next/x=01 leave matched and revealed unchanged.
REQ-041 rst pulsed low mid-HOLD -> all outputs at reset values immediately, without waiting for a clock edge.
